// File: rtl/usb_cdc_send_arbiter.sv
// usb_cdc_send_arbiter: packet-atomic round-robin arbiter sharing the CDC send byte channel among N sources.
// Define CDC_ARB_TAG_EN to prefix every burst with a tag byte 8'hF0+grant_id.
module usb_cdc_send_arbiter #(
    parameter int N             = 4,
    parameter int MAX_BURST     = 64,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           usb_rstn,
    input  logic [8*N-1:0] req_data_i,
    input  logic [N-1:0]   req_valid_i,
    input  logic [N-1:0]   req_last_i,
    output logic [N-1:0]   req_ready_o,
    output logic [7:0]     send_data_o,
    output logic           send_valid_o,
    input  logic           send_ready_i,
    output logic [2:0]     grant_id_o,
    output logic           busy_o
);
    localparam int IW = $clog2(N);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd2;
`ifdef CDC_ARB_TAG_EN
    localparam logic [1:0] TAG = 2'd1;
    localparam logic [1:0] GRANTED = TAG;
`else
    localparam logic [1:0] GRANTED = XFER;
`endif

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]    req_bytes [N];
    logic          g_valid, g_last, hs;

    for (genvar i = 0; i < N; i++) begin : g_bytes
        assign req_bytes[i] = req_data_i[8*i +: 8];
    end

    assign g_valid    = req_valid_i[grant_q];
    assign g_last     = req_last_i[grant_q];
    assign hs         = (state_q == XFER) && g_valid && send_ready_i;
    assign grant_id_o = 3'(grant_q);
    assign busy_o     = state_q != IDLE;

    // First valid requester after the previous grant; descending scan so the nearest one wins.
    always_comb begin
        pick = '0;
        for (int k = N; k >= 1; k--)
            if (req_valid_i[IW'((int'(rr_ptr_q) + k) % N)]) pick = IW'((int'(rr_ptr_q) + k) % N);
    end

    // Grant, burst-length and stall bookkeeping; a burst ends on last, byte limit or stall.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE) begin
            if (|req_valid_i) begin
                state_d     = GRANTED;
                rr_ptr_d    = pick;
                grant_d     = pick;
                burst_cnt_d = '0;
                stall_cnt_d = '0;
            end
        end
`ifdef CDC_ARB_TAG_EN
        else if (state_q == TAG) begin
            if (send_ready_i) state_d = XFER;
        end
`endif
        else if (state_q == XFER) begin
            burst_cnt_d = hs ? burst_cnt_q + 1'b1 : burst_cnt_q;
            stall_cnt_d = g_valid ? '0 : (stall_cnt_q == SW'(STALL_TIMEOUT) ? stall_cnt_q : stall_cnt_q + 1'b1);
            if ((hs && (g_last || burst_cnt_q == BW'(MAX_BURST - 1))) ||
                (!g_valid && stall_cnt_q == SW'(STALL_TIMEOUT - 1)))
                state_d = IDLE;
        end
        else begin
            state_d = IDLE;
        end
    end

    // Zero-latency pass-through of the granted requester, plus the tag byte when compiled in.
    always_comb begin
        send_data_o  = (state_q == XFER) ? req_bytes[grant_q] : 8'h00;
        send_valid_o = (state_q == XFER) && g_valid;
        req_ready_o  = (state_q == XFER && send_ready_i) ? N'(1) << grant_q : '0;
`ifdef CDC_ARB_TAG_EN
        if (state_q == TAG) begin
            send_data_o  = {5'b11110, 3'(grant_q)};
            send_valid_o = 1'b1;
        end
`endif
    end

    // State registers; reset leaves requester 0 first in the round-robin order.
    always_ff @(posedge clk or negedge usb_rstn) begin
        if (!usb_rstn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IW'(N - 1);
            grant_q     <= '0;
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_usb_cdc_send_arbiter.sv
// tb_usb_cdc_send_arbiter: scoreboard bench for the CDC send arbiter (N=4, MAX_BURST=64, STALL_TIMEOUT=255).
module tb_usb_cdc_send_arbiter;
    logic        clk = 1'b0;
    logic        usb_rstn;
    logic [31:0] req_data;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [7:0]  send_data;
    logic        send_valid, send_ready;
    logic [2:0]  grant_id;
    logic        busy;

    typedef struct {
        int data;
        int gid;
        int gap;
    } exp_t;

    logic [8:0] src_q [4][$];
    exp_t       exp_q [$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_hs = 0;
    int         gp;

    usb_cdc_send_arbiter #(.N(4), .MAX_BURST(64), .STALL_TIMEOUT(255)) dut (
        .clk(clk), .usb_rstn(usb_rstn),
        .req_data_i(req_data), .req_valid_i(req_valid), .req_last_i(req_last), .req_ready_o(req_ready),
        .send_data_o(send_data), .send_valid_o(send_valid), .send_ready_i(send_ready),
        .grant_id_o(grant_id), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, obs, obs, expv, expv, cyc);
        end
    endtask

    task automatic src_push(input int i, input int d, input bit last);
        src_q[i].push_back({last, d[7:0]});
    endtask

    task automatic exp_push(input int d, input int g, input int gap);
        exp_t e;
        e.data = d;
        e.gid  = g;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Opens a burst: with tagging, the tag byte takes the given gap and data follows one cycle later.
    task automatic exp_start(input int g, input int gap, output int nxt);
`ifdef CDC_ARB_TAG_EN
        exp_push(8'hF0 + g, g, gap);
        nxt = 1;
`else
        nxt = gap;
`endif
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // One clock: score the output at the falling edge, then retire accepted source bytes after the rising edge.
    task automatic tick();
        exp_t       e;
        logic [3:0] hs;
        @(negedge clk);
        if (send_valid && send_ready) begin
            if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("data", send_data, e.data);
                check("gid", grant_id, e.gid);
                if (e.gap >= 0) check("gap", cyc - last_hs, e.gap);
                last_hs = cyc;
            end
        end
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (hs[i]) void'(src_q[i].pop_front());
        drive_inputs();
        cyc++;
    endtask

    task automatic run(input int budget);
        for (int n = 0; n < budget && exp_q.size() > 0; n++) tick();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget && busy; n++) tick();
        check("idle", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_svalid"}, send_valid, 0);
        check({tag, "_sdata"}, send_data, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_gid"}, grant_id, 0);
    endtask

    initial begin
        usb_rstn   = 1'b0;
        send_ready = 1'b1;
        drive_inputs();
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        usb_rstn = 1'b1;
        @(posedge clk);
        #1;

        // Two 3-byte messages from requesters 0 and 2; one idle cycle between bursts.
        exp_start(0, -1, gp);
        exp_push(11, 0, gp); exp_push(12, 0, 1); exp_push(13, 0, 1);
        exp_start(2, 2, gp);
        exp_push(21, 2, gp); exp_push(22, 2, 1); exp_push(23, 2, 1);
        src_push(0, 11, 0); src_push(0, 12, 0); src_push(0, 13, 1);
        src_push(2, 21, 0); src_push(2, 22, 0); src_push(2, 23, 1);
        drive_inputs();
        run(50);

        // 100-byte stream from requester 1 is split at 64 bytes to serve requester 3.
        exp_start(1, -1, gp);
        for (int i = 0; i < 64; i++) exp_push(i, 1, i == 0 ? gp : 1);
        exp_start(3, 2, gp);
        for (int i = 0; i < 4; i++) exp_push(200 + i, 3, i == 0 ? gp : 1);
        exp_start(1, 2, gp);
        for (int i = 64; i < 100; i++) exp_push(i, 1, i == 64 ? gp : 1);
        for (int i = 0; i < 100; i++) src_push(1, i, 0);
        drive_inputs();
        tick();
        for (int i = 0; i < 4; i++) src_push(3, 200 + i, i == 3);
        drive_inputs();
        tick();
        #1;
        check("other_ready", req_ready[3], 0);
        check("other_valid", req_valid[3], 1);
        run(400);
        wait_idle(400);

        // Requester 0 stalls after 2 bytes; pending requester 1 follows after the timeout.
        exp_start(0, -1, gp);
        exp_push(8'h01, 0, gp); exp_push(8'h02, 0, 1);
        exp_start(1, 257, gp);
        exp_push(8'h31, 1, gp);
        src_push(0, 8'h01, 0); src_push(0, 8'h02, 0);
        src_push(1, 8'h31, 1);
        drive_inputs();
        run(400);

        // Backpressure for 500 cycles is not a stall; the held byte stays on the bus.
        exp_start(2, -1, gp);
        exp_push(8'h41, 2, gp); exp_push(8'h42, 2, 501); exp_push(8'h43, 2, 1); exp_push(8'h44, 2, 1);
        for (int i = 0; i < 4; i++) src_push(2, 8'h41 + i, i == 3);
        drive_inputs();
        for (int n = 0; n < 50 && exp_q.size() > 3; n++) tick();
        check("bp_start", exp_q.size(), 3);
        send_ready = 1'b0;
        repeat (500) tick();
        #1;
        check("bp_busy", busy, 1);
        check("bp_svalid", send_valid, 1);
        check("bp_sdata", send_data, 8'h42);
        check("bp_gid", grant_id, 2);
        send_ready = 1'b1;
        run(50);

        // Single-byte message from requester 2 with the first outgoing byte held by backpressure.
        send_ready = 1'b0;
        exp_start(2, -1, gp);
        exp_push(8'h55, 2, gp);
        src_push(2, 8'h55, 1);
        drive_inputs();
        repeat (5) tick();
        #1;
        check("hold_svalid", send_valid, 1);
`ifdef CDC_ARB_TAG_EN
        check("hold_sdata", send_data, 8'hF2);
`else
        check("hold_sdata", send_data, 8'h55);
`endif
        check("hold_gid", grant_id, 2);
        send_ready = 1'b1;
        run(50);

        // Reset in the middle of a burst from requester 1, then requester 0 wins first.
        exp_start(1, -1, gp);
        exp_push(8'h60, 1, gp); exp_push(8'h61, 1, 1); exp_push(8'h62, 1, 1);
        for (int i = 0; i < 10; i++) src_push(1, 8'h60 + i, i == 9);
        drive_inputs();
        run(50);
        #1;
        check("pre_rst_busy", busy, 1);
        usb_rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 4; i++) src_q[i].delete();
        drive_inputs();
        #1;
        usb_rstn = 1'b1;
        exp_start(0, -1, gp);
        exp_push(8'h70, 0, gp);
        exp_start(1, 2, gp);
        exp_push(8'h71, 1, gp);
        src_push(0, 8'h70, 1);
        src_push(1, 8'h71, 1);
        drive_inputs();
        run(50);
        wait_idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
